// File: rtl/m_bitserial_logic_pkg.sv
// m_bitserial_logic_pkg: opcodes, FSM states and opcode width shared by the bit-serial logic unit
package m_bitserial_logic_pkg;
    localparam int OP_W = 3;
    localparam logic [OP_W-1:0] OP_NOT_A  = 3'd0;
    localparam logic [OP_W-1:0] OP_AND    = 3'd1;
    localparam logic [OP_W-1:0] OP_NAND   = 3'd2;
    localparam logic [OP_W-1:0] OP_OR     = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR    = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR    = 3'd5;
    localparam logic [OP_W-1:0] OP_XNOR   = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS_A = 3'd7;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
endpackage

// File: rtl/m_bitserial_logic_nand_slice.sv
// m_nand_slice: SLICE-wide opcode-selected logic cell built only from two-input nand gates
module m_nand_slice
    import m_bitserial_logic_pkg::*;
#(
    parameter int SLICE = 1
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic [OP_W-1:0]  i_op,
    output logic [SLICE-1:0] o_y
);
    logic [OP_W-1:0] w_ns;
    for (genvar s = 0; s < OP_W; s++) begin : g_ns
        nand u_inv (w_ns[s], i_op[s], i_op[s]);
    end
    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        logic [7:0] w_f;
        logic [3:0] w_m1;
        logic [1:0] w_m2;
        logic       w_nb, w_t2, w_t3, w_p3, w_q3;
        nand u_na   (w_f[0], i_a[i], i_a[i]);
        nand u_nand (w_f[2], i_a[i], i_b[i]);
        nand u_and  (w_f[1], w_f[2], w_f[2]);
        nand u_nb   (w_nb, i_b[i], i_b[i]);
        nand u_or   (w_f[3], w_f[0], w_nb);
        nand u_nor  (w_f[4], w_f[3], w_f[3]);
        nand u_t2   (w_t2, i_a[i], w_f[2]);
        nand u_t3   (w_t3, i_b[i], w_f[2]);
        nand u_xor  (w_f[5], w_t2, w_t3);
        nand u_xnor (w_f[6], w_f[5], w_f[5]);
        nand u_pass (w_f[7], w_f[0], w_f[0]);
        // 8:1 select as a tree of nand 2:1 muxes: y = nand(nand(x0,~s), nand(x1,s))
        for (genvar k = 0; k < 4; k++) begin : g_m1
            logic w_p, w_q;
            nand u_p (w_p, w_f[2*k], w_ns[0]);
            nand u_q (w_q, w_f[2*k+1], i_op[0]);
            nand u_m (w_m1[k], w_p, w_q);
        end
        for (genvar k = 0; k < 2; k++) begin : g_m2
            logic w_p, w_q;
            nand u_p (w_p, w_m1[2*k], w_ns[1]);
            nand u_q (w_q, w_m1[2*k+1], i_op[1]);
            nand u_m (w_m2[k], w_p, w_q);
        end
        nand u_p3 (w_p3, w_m2[0], w_ns[2]);
        nand u_q3 (w_q3, w_m2[1], i_op[2]);
        nand u_m3 (o_y[i], w_p3, w_q3);
    end
endmodule

// File: rtl/m_bitserial_logic.sv
// m_bitserial_logic: valid/ready bitwise logic unit evaluating SLICE bits per clock, LSB slice first
module m_bitserial_logic
    import m_bitserial_logic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_a,
    input  logic [WIDTH-1:0] i_in_b,
    input  logic [OP_W-1:0]  i_in_op,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_y,
    output logic             o_out_zero,
    output logic             o_busy
);
    localparam int STEPS = WIDTH / SLICE;
    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
    if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
        $error("m_bitserial_logic: SLICE must be >= 1 and divide WIDTH");
    end
    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a, r_b, r_y, w_y_full;
    logic [OP_W-1:0]  r_op;
    logic             r_zero, w_last, w_accept;
    logic [SLICE-1:0] w_y_sl;
    assign w_last   = r_cnt == CW'(STEPS - 1);
    assign w_accept = r_state == ST_IDLE && i_in_valid;
    m_nand_slice #(.SLICE(SLICE)) u_cell (
        .i_a  (r_a[SLICE-1:0]),
        .i_b  (r_b[SLICE-1:0]),
        .i_op (r_op),
        .o_y  (w_y_sl)
    );
    // operands shift down and results shift in from the top, so slice 0 lands at the LSB
    if (STEPS == 1) begin : g_one
        assign w_y_full = w_y_sl;
    end else begin : g_many
        assign w_y_full = {w_y_sl, r_y[WIDTH-1:SLICE]};
    end
    always_comb begin
        w_next = w_accept ? ST_RUN :
                 (r_state == ST_RUN && w_last) ? ST_DONE :
                 (r_state == ST_DONE && i_out_ready) ? ST_IDLE : r_state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_y    <= '0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_a   <= i_in_a;
            r_b   <= i_in_b;
            r_op  <= i_in_op;
        end else if (r_state == ST_RUN) begin
            r_a   <= r_a >> SLICE;
            r_b   <= r_b >> SLICE;
            r_y   <= w_y_full;
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) r_zero <= ~|w_y_full;
        end
    end
    assign o_in_ready  = r_state == ST_IDLE;
    assign o_out_valid = r_state == ST_DONE;
    assign o_busy      = r_state != ST_IDLE;
    assign o_out_y     = r_y;
    assign o_out_zero  = r_zero;
endmodule

// File: tb/tb_m_bitserial_logic.sv
// tb_m_bitserial_logic: random and directed checks of two instances (SLICE=1 and SLICE=4) against a transaction model
module tb_m_bitserial_logic;
    import m_bitserial_logic_pkg::*;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       iv[2], ir[2], ov[2], ordy[2], oz[2], bsy[2];
    logic [7:0] ia[2], ib[2], oy[2];
    logic [2:0] iop[2];
    int         n_chk = 0, n_fail = 0, cyc = 0;
    logic       m_busy[2];
    int         m_vc[2];
    logic [7:0] m_y[2];
    always #5 clk = ~clk;
    m_bitserial_logic #(.WIDTH(8), .SLICE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(iv[0]), .o_in_ready(ir[0]),
        .i_in_a(ia[0]), .i_in_b(ib[0]), .i_in_op(iop[0]), .o_out_valid(ov[0]),
        .i_out_ready(ordy[0]), .o_out_y(oy[0]), .o_out_zero(oz[0]), .o_busy(bsy[0]));
    m_bitserial_logic #(.WIDTH(8), .SLICE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(iv[1]), .o_in_ready(ir[1]),
        .i_in_a(ia[1]), .i_in_b(ib[1]), .i_in_op(iop[1]), .o_out_valid(ov[1]),
        .i_out_ready(ordy[1]), .o_out_y(oy[1]), .o_out_zero(oz[1]), .o_busy(bsy[1]));
    function automatic int steps(input int d);
        return d == 0 ? 8 : 2;
    endfunction
    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_NOT_A: return ~a;
            OP_AND:   return a & b;
            OP_NAND:  return ~(a & b);
            OP_OR:    return a | b;
            OP_NOR:   return ~(a | b);
            OP_XOR:   return a ^ b;
            OP_XNOR:  return ~(a ^ b);
            default:  return a;
        endcase
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // transaction model: accept when idle, result visible STEPS edges later, retired on out_ready
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) m_busy[d] = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!m_busy[d]) begin
                    if (iv[d]) begin
                        m_busy[d] = 1'b1;
                        m_y[d]    = ref_op(iop[d], ia[d], ib[d]);
                        m_vc[d]   = cyc + 1 + steps(d);
                    end
                end else if (cyc >= m_vc[d] && ordy[d]) m_busy[d] = 1'b0;
            end
            cyc++;
        end
    end
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("in_ready%0d", d), 32'(ir[d]), 32'(!m_busy[d]));
            chk($sformatf("busy%0d", d), 32'(bsy[d]), 32'(m_busy[d]));
            chk($sformatf("out_valid%0d", d), 32'(ov[d]), 32'(m_busy[d] && cyc >= m_vc[d]));
            if (m_busy[d] && cyc >= m_vc[d]) begin
                chk($sformatf("out_y%0d", d), 32'(oy[d]), 32'(m_y[d]));
                chk($sformatf("out_zero%0d", d), 32'(oz[d]), 32'(m_y[d] == 8'h00));
            end
        end
    end
    task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                          input logic [7:0] ey, input logic ez);
        int n = 0;
        iv[d] = 1'b1; ia[d] = a; ib[d] = b; iop[d] = op;
        @(posedge clk); #1;
        iv[d] = 1'b0;
        while (!ov[d] && n < 40) begin @(posedge clk); #1; n++; end
        chk($sformatf("latency%0d", d), 32'(n), 32'(steps(d)));
        chk($sformatf("lit_y%0d_op%0d", d, op), 32'(oy[d]), 32'(ey));
        chk($sformatf("lit_zero%0d_op%0d", d, op), 32'(oz[d]), 32'(ez));
        @(posedge clk); #1;
    endtask
    task automatic rand_run(input int d, input int count);
        int   acc = 0, last = -1, c = 0;
        logic rd;
        iv[d] = 1'b1; ordy[d] = 1'b1;
        while (acc < count && c < count * (steps(d) + 2) + 50) begin
            ia[d] = 8'($urandom); ib[d] = 8'($urandom); iop[d] = 3'($urandom_range(0, 7));
            rd = ir[d];
            @(posedge clk); #1;
            c++;
            if (rd) begin
                if (last >= 0) chk($sformatf("period%0d", d), 32'(c - last), 32'(steps(d) + 2));
                last = c;
                acc++;
            end
        end
        iv[d] = 1'b0;
        chk($sformatf("rand_count%0d", d), 32'(acc), 32'(count));
        repeat (steps(d) + 3) @(posedge clk);
        #1;
    endtask
    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1; ia[d] = '0; ib[d] = '0; iop[d] = '0;
        end
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", 32'(ov[d]), 32'd0);
            chk("rst_out_y", 32'(oy[d]), 32'd0);
            chk("rst_out_zero", 32'(oz[d]), 32'd0);
            chk("rst_busy", 32'(bsy[d]), 32'd0);
            chk("rst_in_ready", 32'(ir[d]), 32'd1);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(0, 8'hA5, 8'h0F, OP_XOR, 8'hAA, 1'b0);
        run_op(0, 8'hF0, 8'h0F, OP_AND, 8'h00, 1'b1);
        run_op(0, 8'hF0, 8'h0F, OP_NAND, 8'hFF, 1'b0);
        // result backpressure with a competing offer
        ordy[0] = 1'b0;
        iv[0] = 1'b1; ia[0] = 8'h12; ib[0] = 8'h34; iop[0] = OP_XOR;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        n = 0;
        while (!ov[0] && n < 40) begin @(posedge clk); #1; n++; end
        chk("bp_latency", 32'(n), 32'd8);
        chk("bp_y", 32'(oy[0]), 32'h26);
        repeat (5) begin
            iv[0] = 1'b1; ia[0] = 8'($urandom); ib[0] = 8'($urandom); iop[0] = OP_PASS_A;
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(ov[0]), 32'd1);
            chk("bp_hold_y", 32'(oy[0]), 32'h26);
            chk("bp_hold_ready", 32'(ir[0]), 32'd0);
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_consumed_valid", 32'(ov[0]), 32'd0);
        chk("bp_consumed_ready", 32'(ir[0]), 32'd1);
        // asynchronous reset in the middle of RUN
        iv[0] = 1'b1; ia[0] = 8'h77; ib[0] = 8'h11; iop[0] = OP_AND;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_run_valid", 32'(ov[0]), 32'd0);
        chk("rst_run_busy", 32'(bsy[0]), 32'd0);
        chk("rst_run_ready", 32'(ir[0]), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(0, 8'h3C, 8'h99, OP_NOT_A, 8'hC3, 1'b0);
        run_op(1, 8'h00, 8'h01, OP_NOR, 8'hFE, 1'b0);
        run_op(1, 8'h5A, 8'hFF, OP_PASS_A, 8'h5A, 1'b0);
        rand_run(0, 200);
        rand_run(1, 50);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/m_bitserial_logic.md
# m_bitserial_logic

Parametrised, sequential successor to the team's NAND-derived gate primitives. It applies one of eight bitwise logic operations to two WIDTH-bit operands, processing SLICE bits per clock through a datapath built exclusively from two-input nand primitives. It sits between a valid/ready operand source and a valid/ready result sink, trading latency for a datapath of only SLICE gate cells.

## Interface
- WIDTH, 8: operand/result width in bits; must be >= 1.
- SLICE, 1: bits processed per cycle; must be >= 1 and divide WIDTH, otherwise elaboration error.
- Derived: STEPS = WIDTH/SLICE; counter width = max(1, $clog2(STEPS)).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand offer.
- in_ready  out  1  block can accept; high only in IDLE.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  3  opcode: 0 NOT_A, 1 AND, 2 NAND, 3 OR, 4 NOR, 5 XOR, 6 XNOR, 7 PASS_A.
- out_valid  out  1  result present; high only in DONE.
- out_ready  in  1  sink accepts result.
- out_y  out  WIDTH  result word.
- out_zero  out  1  high when out_y is all zeros.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid at a rising edge: latch in_a, in_b, in_op, clear step counter, go to RUN. in_valid without acceptance has no effect.
- RUN: each cycle evaluates slice cnt (bits [cnt*SLICE +: SLICE], LSB slice first), writes it into the result register, increments cnt. On the edge where cnt == STEPS-1 the last slice is written and state goes to DONE; out_zero is registered on the same edge from the full result.
- DONE: out_valid=1; out_y, out_zero held stable until out_ready sampled high at a rising edge; then IDLE.
- in_ready=0 throughout RUN and DONE; in_valid, in_a, in_b, in_op are ignored (not sampled) there.
- Latched operands are unaffected by input changes after acceptance.
- Opcode 7 is PASS_A (B ignored); NOT_A also ignores B. No illegal opcodes.
- out_zero = NOR-reduction of out_y.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, out_valid=0, out_y=0, out_zero=0, busy=0, counter 0; in_ready reads 1 (combinational from state). Reset mid-RUN or mid-DONE abandons the transaction; no partial result is ever presented.
- Latency: acceptance at edge E0 -> out_valid high after edge E0+STEPS.
- Throughput with out_ready held high: one operation per STEPS+2 cycles (DONE and IDLE each occupy one cycle).
- STEPS == 1: RUN lasts exactly one cycle; counter terminal condition met on entry.
- out_valid, in_ready, busy are decoded from registered state only; no combinational path from in_valid or out_ready to any output.

## Structure
- Shared package: opcode localparams (OP_NOT_A … OP_PASS_A), state enum, opcode width constant.
- Sub-module m_nand_slice: SLICE-wide, purely combinational, op-selected gate cell composed only of nand primitives (no behavioural operators); instantiated once. Sequential control lives in the top.

## Test plan
- WIDTH=8, SLICE=1, a=0xA5, b=0x0F, op XOR -> out_y=0xAA, out_zero=0, out_valid rises 8 cycles after acceptance.
- a=0xF0, b=0x0F, op AND -> out_y=0x00, out_zero=1; op NAND on same operands -> 0xFF, out_zero=0.
- Result backpressure: out_ready low 5 cycles in DONE -> out_y, out_valid stable, in_ready=0, a concurrent in_valid with new operands is ignored; result consumed on first out_ready edge.
- rst_n pulsed low during RUN step 3 -> out_valid=0, busy=0, in_ready=1 immediately; next op (op NOT_A, a=0x3C) returns 0xC3.
- WIDTH=8, SLICE=4: op NOR, a=0x00, b=0x01 -> 0xFE after 2 cycles; op 7 PASS_A a=0x5A, b=0xFF -> 0x5A.
- 200 random back-to-back transactions, all opcodes, out_ready always 1 -> every result matches model, issue period exactly STEPS+2 cycles.
